// File: rtl/mat_pkg.sv
// Shared types and default widths for the matrix stream reader and its FIFO.
package mat_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DIM_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry valid/ready FIFO; the head entry drives the output directly and
// the current occupancy is exported so the producer can pace itself.
module stream_fifo2 import mat_pkg::*; #(
    parameter int W = DEF_DATA_W
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         push;
    logic         pop;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    // NOTE: storage is reset as well, so out_data_o reads 0 out of reset instead of stale data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mat_stream_reader.sv
// Streams a rows x cols matrix out of a synchronous RAM in row-major order,
// buffering read data in a 2-entry FIFO so the consumer can stall freely.
module mat_stream_reader import mat_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DIM_W  = DEF_DIM_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  rows,
    input  logic [DIM_W-1:0]  cols,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = 2 * DIM_W;

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  total_q;
    logic [CNT_W-1:0]  issued_q;
    logic [CNT_W-1:0]  xfer_cnt_q;
    logic              inflight_q;
    logic              xfer;
    logic              last_issue;
    logic              fifo_in_ready;
    logic [1:0]        fifo_count;
    logic [2:0]        pending;

    stream_fifo2 #(.W(DATA_W)) u_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid_i  (inflight_q),
        .in_data_i   (mem_rdata),
        .in_ready_o  (fifo_in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
        .count_o     (fifo_count)
    );

    // Elements already committed to the FIFO once this cycle's transfer is accounted for.
    assign xfer       = out_valid && out_ready;
    assign pending    = 3'(fifo_count) + 3'(inflight_q) - 3'(xfer);
    assign mem_re     = (state_q == ST_READ) && (issued_q < total_q) && (pending < 3'd2);
    assign mem_addr   = base_q + ADDR_W'(issued_q);
    assign last_issue = mem_re && ((issued_q + CNT_W'(1)) == total_q);
    assign out_last   = out_valid && (xfer_cnt_q == (total_q - CNT_W'(1)));
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);

    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            total_q    <= '0;
            issued_q   <= '0;
            xfer_cnt_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= mem_re;
            if (mem_re) begin
                issued_q <= issued_q + CNT_W'(1);
            end
            if (xfer) begin
                xfer_cnt_q <= xfer_cnt_q + CNT_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        base_q     <= base_addr;
                        total_q    <= CNT_W'(rows) * CNT_W'(cols);
                        issued_q   <= '0;
                        xfer_cnt_q <= '0;
                        state_q    <= (rows == '0 || cols == '0) ? ST_DONE : ST_READ;
                    end
                end
                ST_READ: begin
                    if (last_issue) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (xfer && out_last) begin
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The read pacing must never let a returning element find the FIFO full.
    assert property (@(posedge clock) disable iff (!reset_n) inflight_q |-> fifo_in_ready);

endmodule

// File: tb/tb_mat_stream_reader.sv
// Scoreboard bench for mat_stream_reader: expected addresses and elements are
// queued when a read is started and compared as the DUT issues and transfers them.
module tb_mat_stream_reader;

    typedef struct packed {
        logic        last;
        logic [15:0] data;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [7:0]  rows;
    logic [7:0]  cols;
    logic [9:0]  mem_addr;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    mat_stream_reader #(.DATA_W(16), .ADDR_W(10), .DIM_W(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .rows      (rows),
        .cols      (cols),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [9:0] exp_addr_q [$];
    exp_t       exp_data_q [$];

    int          outstanding;
    int          n_re, n_valid, n_xfer, n_done;
    int          start_cyc, first_re_cyc, first_valid_cyc, first_xfer_cyc, last_xfer_cyc, done_cyc;
    bit          stall_pending;
    logic [15:0] stall_data;
    bit          xfer_now;
    exp_t        e;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [15:0] mem_val(input logic [9:0] a);
        return {6'b0, a} ^ 16'hC3A0;
    endfunction

    // Synchronous RAM model: data valid the cycle after mem_re.
    always @(posedge clock) begin
        if (mem_re) mem_rdata <= mem_val(mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic clear_stats();
        n_re = 0; n_valid = 0; n_xfer = 0; n_done = 0;
        start_cyc = -1; first_re_cyc = -1; first_valid_cyc = -1;
        first_xfer_cyc = -1; last_xfer_cyc = -1; done_cyc = -1;
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (!reset_n) begin
            outstanding   = 0;
            stall_pending = 0;
        end else begin
            xfer_now = out_valid && out_ready;
            if (mem_re) begin
                n_re++;
                if (first_re_cyc < 0) first_re_cyc = cyc;
                check("re_gate", 32'((outstanding - int'(xfer_now)) < 2), 1);
                if (exp_addr_q.size() == 0) check("unexp_re", 32'(mem_re), 0);
                else check("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
            end
            if (stall_pending) begin
                check("stall_valid", 32'(out_valid), 1);
                check("stall_data", 32'(out_data), 32'(stall_data));
            end
            stall_pending = out_valid && !out_ready;
            stall_data    = out_data;
            if (out_valid) begin
                n_valid++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (xfer_now) begin
                n_xfer++;
                if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
                if (exp_data_q.size() == 0) check("unexp_valid", 32'(out_valid), 0);
                else begin
                    e = exp_data_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_last", 32'(out_last), 32'(e.last));
                end
                if (out_last) last_xfer_cyc = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            outstanding += int'(mem_re) - int'(xfer_now);
        end
    end

    task automatic start_read(input logic [9:0] b, input logic [7:0] r, input logic [7:0] c);
        int         total;
        logic [9:0] a;
        total = int'(r) * int'(c);
        for (int i = 0; i < total; i++) begin
            a = b + 10'(i);
            exp_addr_q.push_back(a);
            exp_data_q.push_back('{last: (i == total - 1), data: mem_val(a)});
        end
        @(posedge clock); #1;
        start = 1'b1; base_addr = b; rows = r; cols = c;
        start_cyc = cyc;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic run_until_done(input bit toggle, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clock); #2;
            if (n_done > 0) begin
                seen = 1'b1;
                break;
            end
            if (toggle) out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        check("done_seen", 32'(seen), 1);
        repeat (3) @(posedge clock);
        #2;
        check("done_once", 32'(n_done), 1);
        check("idle_busy", 32'(busy), 0);
        check("sb_empty", 32'(exp_data_q.size() + exp_addr_q.size()), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mem_re"}, 32'(mem_re), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_last"}, 32'(out_last), 0);
        check({tag, "_out_data"}, 32'(out_data), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    initial begin
        bit reached;
        reset_n = 1'b0; start = 1'b0; base_addr = '0; rows = '0; cols = '0; out_ready = 1'b1;
        clear_stats();
        repeat (3) @(posedge clock);
        #1;
        check_outputs_zero("rst");
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_outputs_zero("post_rst");

        // 2x3 from 0x010 with the consumer always ready.
        clear_stats();
        start_read(10'h010, 8'd2, 8'd3);
        run_until_done(1'b0, 100);
        check("t1_first_re", 32'(first_re_cyc - start_cyc), 1);
        check("t1_first_valid", 32'(first_valid_cyc - start_cyc), 3);
        check("t1_xfers", 32'(n_xfer), 6);
        check("t1_consec", 32'(last_xfer_cyc - first_xfer_cyc), 5);
        check("t1_done_lat", 32'(done_cyc - last_xfer_cyc), 1);

        // 1x4 with out_ready toggling every cycle.
        clear_stats();
        start_read(10'h100, 8'd1, 8'd4);
        run_until_done(1'b1, 100);
        check("t2_xfers", 32'(n_xfer), 4);
        check("t2_reads", 32'(n_re), 4);

        // Address wrap-around at the top of the 10-bit space.
        clear_stats();
        start_read(10'h3FE, 8'd1, 8'd4);
        run_until_done(1'b0, 100);
        check("t3_reads", 32'(n_re), 4);
        check("t3_xfers", 32'(n_xfer), 4);

        // Empty matrix: straight to DONE.
        clear_stats();
        start_read(10'h020, 8'd0, 8'd5);
        run_until_done(1'b0, 20);
        check("t4_done_lat", 32'(done_cyc - start_cyc), 1);
        check("t4_no_re", 32'(n_re), 0);
        check("t4_no_valid", 32'(n_valid), 0);

        // Reset in the middle of a 4x4 read, then a clean restart.
        clear_stats();
        start_read(10'h040, 8'd4, 8'd4);
        reached = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clock); #2;
            if (n_xfer >= 3) begin
                reached = 1'b1;
                break;
            end
        end
        check("t5_reached_3", 32'(reached), 1);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("t5_mid_rst");
        exp_addr_q.delete();
        exp_data_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        clear_stats();
        repeat (6) @(posedge clock);
        #2;
        check("t5_idle_busy", 32'(busy), 0);
        check("t5_no_valid", 32'(n_valid), 0);
        check("t5_no_re", 32'(n_re), 0);
        start_read(10'h040, 8'd4, 8'd4);
        run_until_done(1'b0, 200);
        check("t5_xfers", 32'(n_xfer), 16);

        // start held while busy must not disturb the running 2x2 read.
        clear_stats();
        start_read(10'h080, 8'd2, 8'd2);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            start = 1'b1; base_addr = 10'h200; rows = 8'd3; cols = 8'd3;
        end
        @(posedge clock); #1;
        start = 1'b0;
        run_until_done(1'b0, 100);
        check("t6_xfers", 32'(n_xfer), 4);
        check("t6_reads", 32'(n_re), 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
